// File: rtl/serial_rx_pkg.sv
// Shared types, constants and the parity helper for the serial frame receiver.
package serial_rx_pkg;

    localparam int   STATE_W    = 3;
    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [STATE_W-1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    // Zero-extended data does not change the XOR, so one width serves every DATA_W up to 64.
    function automatic logic rx_parity(input logic [63:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/serial_rx_shifter.sv
// Data shift register (LSB first) and bit counter for the serial frame receiver.
module serial_rx_shifter #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              shift_en,
    input  logic              clear,
    input  logic              din,
    output logic [DATA_W-1:0] word,
    output logic              last_bit
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [CNT_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word  <= '0;
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (shift_en) begin
            word  <= {din, word[DATA_W-1:1]};
            count <= last_bit ? '0 : count + 1'b1;
        end
    end

    assign last_bit = (count == CNT_W'(DATA_W - 1));

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start / data / optional parity / stop framing into parallel words with error flags.
module serial_frame_rx
    import serial_rx_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int PARITY_EN  = 1,
    parameter int ODD_PARITY = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din,
    input  logic              bit_en,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    rx_state_t         state;
    logic              parity_bit;
    logic [DATA_W-1:0] word;
    logic              last_bit;
    logic              shift_en;
    logic              clear;

    assign shift_en = bit_en && (state == DATA);
    assign clear    = bit_en && (state == IDLE) && (din != IDLE_LEVEL);
    assign busy     = (state != IDLE);

    serial_rx_shifter #(
        .DATA_W (DATA_W)
    ) u_shifter (
        .clk      (clk),
        .rst      (rst),
        .shift_en (shift_en),
        .clear    (clear),
        .din      (din),
        .word     (word),
        .last_bit (last_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            parity_bit <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (bit_en) begin
                case (state)
                    IDLE: begin
                        if (din != IDLE_LEVEL)
                            state <= DATA;
                    end
                    DATA: begin
                        if (last_bit)
                            state <= (PARITY_EN != 0) ? PARITY : STOP;
                    end
                    PARITY: begin
                        parity_bit <= din;
                        state      <= STOP;
                    end
                    STOP: begin
                        // The word is delivered even on errors; downstream qualifies it with the flags.
                        data_out   <= word;
                        data_valid <= 1'b1;
                        parity_err <= (PARITY_EN != 0) &&
                                      (parity_bit != rx_parity(64'(word), ODD_PARITY != 0));
                        frame_err  <= ~din;
                        state      <= (din == IDLE_LEVEL) ? IDLE : BREAK;
                    end
                    BREAK: begin
                        if (din == IDLE_LEVEL)
                            state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Self-checking bench for serial_frame_rx: frame-level scoreboard plus directed and random frames.
module tb_serial_frame_rx;

    localparam logic ODD = 1'b0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       din = 1'b1;
    logic       bit_en = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    serial_frame_rx #(
        .DATA_W     (8),
        .PARITY_EN  (1),
        .ODD_PARITY (0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .bit_en     (bit_en),
        .data_out   (data_out),
        .data_valid (data_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Expected outputs after the coming rising edge, set by the driver from frame contents.
    logic [7:0] exp_data  = 8'h00;
    logic       exp_valid = 1'b0;
    logic       exp_perr  = 1'b0;
    logic       exp_ferr  = 1'b0;
    logic       exp_busy  = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int period   = 1;
    int cyc      = 0;
    int vtimes[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        #2;
        check("data_valid", 32'(data_valid), 32'(exp_valid));
        check("data_out",   32'(data_out),   32'(exp_data));
        check("parity_err", 32'(parity_err), 32'(exp_perr));
        check("frame_err",  32'(frame_err),  32'(exp_ferr));
        check("busy",       32'(busy),       32'(exp_busy));
        if (data_valid)
            vtimes.push_back(cyc);
    end

    // One sampled bit, preceded by period-1 cycles without a strobe and with random din.
    task automatic strobe(input logic d, input logic busy_after, input logic is_stop = 1'b0,
                          input logic [7:0] w = 8'h00, input logic pe = 1'b0, input logic fe = 1'b0);
        for (int i = 0; i < period - 1; i++) begin
            @(negedge clk);
            bit_en    = 1'b0;
            din       = 1'($urandom);
            exp_valid = 1'b0;
        end
        @(negedge clk);
        bit_en    = 1'b1;
        din       = d;
        exp_valid = is_stop;
        exp_busy  = busy_after;
        if (is_stop) begin
            exp_data = w;
            exp_perr = pe;
            exp_ferr = fe;
        end
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bit_en    = 1'b0;
            din       = 1'($urandom);
            exp_valid = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] w, input logic flip, input logic stop_b);
        logic p;
        p = (^w) ^ ODD ^ flip;
        strobe(1'b0, 1'b1);
        for (int i = 0; i < 8; i++)
            strobe(w[i], 1'b1);
        strobe(p, 1'b1);
        strobe(stop_b, ~stop_b, 1'b1, w, flip, ~stop_b);
    endtask

    task automatic recover(input int zeros);
        for (int i = 0; i < zeros; i++)
            strobe(1'b0, 1'b1);
        strobe(1'b1, 1'b0);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #3;
    endtask

    initial begin
        logic [7:0] w;
        logic       flip;
        logic       stop_b;

        #1;
        check("reset data_out", 32'(data_out), 32'h0);
        check("reset busy", 32'(busy), 32'h0);
        quiet(2);
        rst = 1'b0;
        quiet(2);

        // Good frame
        send_frame(8'hA5, 1'b0, 1'b1);
        after_edge();
        check("t1 valid", 32'(data_valid), 32'h1);
        check("t1 data", 32'(data_out), 32'hA5);
        check("t1 perr", 32'(parity_err), 32'h0);
        quiet(1);
        after_edge();
        check("t1 valid pulse", 32'(data_valid), 32'h0);
        check("t1 busy idle", 32'(busy), 32'h0);

        // Parity error, then a good frame clears it
        send_frame(8'hA5, 1'b1, 1'b1);
        after_edge();
        check("t2 perr", 32'(parity_err), 32'h1);
        check("t2 data", 32'(data_out), 32'hA5);
        send_frame(8'h3C, 1'b0, 1'b1);
        after_edge();
        check("t2 perr cleared", 32'(parity_err), 32'h0);
        check("t2 data2", 32'(data_out), 32'h3C);

        // Framing error and break
        send_frame(8'h5A, 1'b0, 1'b0);
        after_edge();
        check("t3 ferr", 32'(frame_err), 32'h1);
        for (int i = 0; i < 5; i++)
            strobe(1'b0, 1'b1);
        after_edge();
        check("t3 busy in break", 32'(busy), 32'h1);
        check("t3 no new frame", 32'(data_valid), 32'h0);
        strobe(1'b1, 1'b0);
        after_edge();
        check("t3 busy released", 32'(busy), 32'h0);

        // Asynchronous reset mid-frame
        strobe(1'b0, 1'b1);
        for (int i = 0; i < 3; i++)
            strobe(1'b1, 1'b1);
        @(negedge clk);
        #2;
        rst       = 1'b1;
        bit_en    = 1'b0;
        exp_valid = 1'b0;
        exp_data  = 8'h00;
        exp_perr  = 1'b0;
        exp_ferr  = 1'b0;
        exp_busy  = 1'b0;
        #1;
        check("t4 async data_out", 32'(data_out), 32'h0);
        check("t4 async ferr", 32'(frame_err), 32'h0);
        check("t4 async busy", 32'(busy), 32'h0);
        quiet(2);
        rst = 1'b0;
        send_frame(8'h3C, 1'b0, 1'b1);
        after_edge();
        check("t4 data", 32'(data_out), 32'h3C);
        check("t4 ferr", 32'(frame_err), 32'h0);

        // Sparse strobe
        period = 4;
        send_frame(8'h81, 1'b0, 1'b1);
        after_edge();
        check("t5 data", 32'(data_out), 32'h81);
        period = 1;
        quiet(2);

        // Back-to-back frames
        vtimes.delete();
        send_frame(8'h01, 1'b0, 1'b1);
        send_frame(8'hFE, 1'b0, 1'b1);
        quiet(2);
        check("t6 pulse count", 32'(vtimes.size()), 32'd2);
        if (vtimes.size() == 2)
            check("t6 pulse spacing", 32'(vtimes[1] - vtimes[0]), 32'd11);
        check("t6 data", 32'(data_out), 32'hFE);

        // Randomised frames with varying strobe density, errors, breaks and idle gaps
        for (int f = 0; f < 40; f++) begin
            period = $urandom_range(1, 3);
            w      = 8'($urandom);
            flip   = ($urandom_range(0, 3) == 0);
            stop_b = ($urandom_range(0, 4) != 0);
            send_frame(w, flip, stop_b);
            if (!stop_b)
                recover($urandom_range(0, 3));
            for (int g = 0; g < int'($urandom_range(0, 2)); g++)
                strobe(1'b1, 1'b0);
        end
        period = 1;
        quiet(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
